// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit four-register datapath: opcodes,
// ALU operation codes and the multi-cycle controller state encoding.
package mips16_pkg;

  // Instruction opcodes (ir[15:12])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_ADDI = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  // ALU operation select codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  // Controller states; encoding is visible on the debug state port
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4,
    BRANCH    = 3'd5
  } state_e;

endpackage

// File: rtl/mc_decode.sv
// Opcode decoder for the multi-cycle controller. Purely combinational.
// valid marks ALU/addi opcodes; is_branch marks beq, which is only
// recognised when MC_BRANCH_EN is defined (otherwise 1000 is illegal).
module mc_decode
  import mips16_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       valid,
  output logic       is_branch,
  output logic       reg_dst,
  output logic       alu_src,
  output logic [3:0] alu_control
);

  // Opcode to ALU select / destination / operand-source map
  always_comb begin
    valid       = 1'b0;
    is_branch   = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    alu_control = ALU_AND;
    case (opcode)
      OP_ADD:  begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_ADD;  end
      OP_SUB:  begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_SUB;  end
      OP_AND:  begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_AND;  end
      OP_OR:   begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_OR;   end
      OP_NOR:  begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_NOR;  end
      OP_NAND: begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_NAND; end
      OP_SLT:  begin valid = 1'b1; reg_dst = 1'b1; alu_control = ALU_SLT;  end
      OP_ADDI: begin valid = 1'b1; alu_src = 1'b1; alu_control = ALU_ADD;  end
`ifdef MC_BRANCH_EN
      OP_BEQ:  begin is_branch = 1'b1; alu_control = ALU_SUB; end
`endif
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit
// datapath. Handshakes with a wait-stated instruction memory, drives the
// IR/PC/register-file strobes and the ALU select, and stops on HALT_WORD.
// Optional feature: define MC_BRANCH_EN to enable beq (opcode 1000) via
// the BRANCH state; without it opcode 1000 is skipped as illegal.
module multicycle_controller
  import mips16_pkg::*;
#(
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        imem_ready,
  input  logic        zero,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [3:0]  alu_control,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;

  logic        imem_req_s, ir_write_s, pc_write_s, reg_write_s;

  logic        dec_valid, dec_is_branch, dec_reg_dst, dec_alu_src;
  logic [3:0]  dec_alu_control;

`ifndef MC_BRANCH_EN
  // zero only matters for beq
  logic        unused_zero;
  assign unused_zero = zero;
`endif

  mc_decode u_decode (
    .opcode      (ir[15:12]),
    .valid       (dec_valid),
    .is_branch   (dec_is_branch),
    .reg_dst     (dec_reg_dst),
    .alu_src     (dec_alu_src),
    .alu_control (dec_alu_control)
  );

  // State and retired-instruction counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state, strobe and select decode
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    imem_req_s  = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    pc_src      = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    alu_control = ALU_AND;
    case (state_q)
      FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ready) begin
          ir_write_s = 1'b1;
          state_d    = DECODE;
        end else begin
          state_d    = FETCH;
        end
      end
      DECODE: begin
        if (ir == HALT_WORD) begin
          state_d = HALT;
        end else if (dec_valid) begin
          state_d = EXECUTE;
`ifdef MC_BRANCH_EN
        end else if (dec_is_branch) begin
          state_d = BRANCH;
`endif
        end else begin
          // Illegal opcode: step over it without retiring
          pc_write_s = 1'b1;
          state_d    = FETCH;
        end
      end
      EXECUTE: begin
        reg_dst     = dec_reg_dst;
        alu_src     = dec_alu_src;
        alu_control = dec_alu_control;
        state_d     = WRITEBACK;
      end
      WRITEBACK: begin
        reg_dst     = dec_reg_dst;
        alu_src     = dec_alu_src;
        alu_control = dec_alu_control;
        reg_write_s = 1'b1;
        pc_write_s  = 1'b1;
        count_d     = count_q + 16'd1;
        state_d     = FETCH;
      end
`ifdef MC_BRANCH_EN
      BRANCH: begin
        alu_control = ALU_SUB;
        pc_write_s  = 1'b1;
        pc_src      = zero;
        count_d     = count_q + 16'd1;
        state_d     = FETCH;
      end
`endif
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Strobes are held inactive for the whole time reset is high
  assign imem_req    = imem_req_s  & ~reset;
  assign ir_write    = ir_write_s  & ~reset;
  assign pc_write    = pc_write_s  & ~reset;
  assign reg_write   = reg_write_s & ~reset;
  assign halted      = (state_q == HALT);
  assign instr_count = count_q;
  assign state       = state_q;

  // dec_is_branch is only consumed when branches are enabled
  logic unused_is_branch;
  assign unused_is_branch = dec_is_branch;

endmodule
